// File: rtl/four_bits_signed_accumulator.sv
// Accumulates N_SAMPLES sign-extended 4-bit samples into a SUM_W-bit signed sum,
// with a start/busy/done handshake and a sticky signed-overflow flag.
module four_bits_signed_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int SUM_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       a,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic [3:0]       count,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] LAST_CNT = 4'(N_SAMPLES);

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SUM_W-1:0] sample_ext_s;
    logic [SUM_W-1:0] sum_next_s;
    logic [3:0]       count_next_s;
    logic             step_ovf_s;

    // Width-cast of a signed operand replicates the sign bit.
    function automatic logic [SUM_W-1:0] sign_extend(input logic [3:0] val);
        logic signed [3:0] val_s;
        val_s = signed'(val);
        return SUM_W'(val_s);
    endfunction

    // Signed overflow: operands agree in sign, result sign differs.
    function automatic logic add_overflow(input logic [SUM_W-1:0] x,
                                          input logic [SUM_W-1:0] y,
                                          input logic [SUM_W-1:0] s);
        return (x[SUM_W-1] == y[SUM_W-1]) && (s[SUM_W-1] != x[SUM_W-1]);
    endfunction

    // Datapath for one accepted sample.
    always_comb begin
        sample_ext_s = sign_extend(a);
        sum_next_s   = sum_q + sample_ext_s;
        count_next_s = count_q + 4'd1;
        step_ovf_s   = add_overflow(sum_q, sample_ext_s, sum_next_s);
    end

    // Next-state and next-output logic for the IDLE/ACC/DONE handshake.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                    sum_d   = {SUM_W{1'b0}};
                    count_d = 4'd0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                busy_d = 1'b1;
                if (in_valid) begin
                    sum_d   = sum_next_s;
                    count_d = count_next_s;
                    ovf_d   = ovf_q | step_ovf_s;
                    if (count_next_s == LAST_CNT) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean IDLE.
                state_d = ST_IDLE;
                sum_d   = {SUM_W{1'b0}};
                count_d = 4'd0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sum_q   <= {SUM_W{1'b0}};
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_four_bits_signed_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// integer-arithmetic reference model, on an 8-bit and a 4-bit accumulator.
module tb_four_bits_signed_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = 4'd0;

    logic       busy8, done8, ovf8;
    logic [7:0] sum8;
    logic [3:0] cnt8;
    logic       busy4, done4, ovf4;
    logic [3:0] sum4;
    logic [3:0] cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 is the SUM_W=8 unit, index 1 the SUM_W=4 unit.
    int m_state [2];   // 0 idle, 1 accumulating, 2 done
    int m_sum   [2];
    int m_cnt   [2];
    int m_ovf   [2];
    int m_w     [2] = '{8, 4};

    always #5 clk = ~clk;

    four_bits_signed_accumulator #(.N_SAMPLES(8), .SUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a),
        .busy(busy8), .done(done8), .sum(sum8), .count(cnt8), .overflow(ovf8)
    );

    four_bits_signed_accumulator #(.N_SAMPLES(8), .SUM_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a),
        .busy(busy4), .done(done4), .sum(sum4), .count(cnt4), .overflow(ovf4)
    );

    function automatic int sample_value(input logic [3:0] v);
        return (v >= 4'd8) ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int wrap_signed(input int t, input int w);
        int m;
        m = t % (1 << w);
        if (m < 0) m += (1 << w);
        if (m >= (1 << (w - 1))) m -= (1 << w);
        return m;
    endfunction

    task automatic mdl_step(input int k);
        int t;
        if (rst) begin
            m_state[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end else if (m_state[k] == 0) begin
            if (start) begin
                m_state[k] = 1; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end
        end else if (m_state[k] == 1) begin
            if (in_valid) begin
                t = m_sum[k] + sample_value(a);
                if (t > (1 << (m_w[k] - 1)) - 1 || t < -(1 << (m_w[k] - 1))) m_ovf[k] = 1;
                m_sum[k] = wrap_signed(t, m_w[k]);
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == 8) m_state[k] = 2;
            end
        end else begin
            m_state[k] = 0;
        end
    endtask

    // One clock: model sees the same inputs as the DUTs, then outputs settle.
    task automatic tick();
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy8, done8, sum8, cnt8, ovf8} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h count=%0d ovf=%b, want all 0",
                     busy8, done8, sum8, cnt8, ovf8);
        end
        n_checks++;
        if ({busy4, done4, sum4, cnt4, ovf4} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset4: got busy=%b done=%b sum=%h count=%0d ovf=%b, want all 0",
                     busy4, done4, sum4, cnt4, ovf4);
        end
    endtask

    task automatic test_minus_one();
        int busy_cycles = 0;
        start = 1'b1; tick(); start = 1'b0;
        busy_cycles += int'(busy8);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = 4'hF;
            tick();
            if (i < 7) busy_cycles += int'(busy8);
        end
        in_valid = 1'b0;
        n_checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++; $display("FAIL m1_done: got done=%b busy=%b, want 1 0", done8, busy8);
        end
        n_checks++;
        if (sum8 !== 8'hF8 || cnt8 !== 4'd8 || ovf8 !== 1'b0) begin
            n_fail++; $display("FAIL m1_result: got sum=%h count=%0d ovf=%b, want f8 8 0", sum8, cnt8, ovf8);
        end
        n_checks++;
        if (busy_cycles != 8) begin
            n_fail++; $display("FAIL m1_busy_len: got %0d busy cycles, want 8", busy_cycles);
        end
        tick();
        n_checks++;
        if (done8 !== 1'b0) begin
            n_fail++; $display("FAIL m1_done_pulse: got done=%b after DONE, want 0", done8);
        end
    endtask

    task automatic test_alternating();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = (i % 2 == 0) ? 4'h7 : 4'h8;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (done8 !== 1'b1 || sum8 !== 8'hFC || ovf8 !== 1'b0) begin
            n_fail++; $display("FAIL alt_result: got done=%b sum=%h ovf=%b, want 1 fc 0", done8, sum8, ovf8);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (sum8 !== 8'hFC || cnt8 !== 4'd8 || busy8 !== 1'b0 || done8 !== 1'b0 || ovf8 !== 1'b0) begin
                n_fail++;
                $display("FAIL alt_hold: cycle %0d got sum=%h count=%0d busy=%b done=%b ovf=%b, want fc 8 0 0 0",
                         i, sum8, cnt8, busy8, done8, ovf8);
            end
        end
    endtask

    task automatic test_gaps();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int gap = $urandom_range(1, 4);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; a = 4'($urandom_range(0, 15));
                tick();
                n_checks++;
                if (cnt8 !== 4'(i) || busy8 !== 1'b1) begin
                    n_fail++; $display("FAIL gap_hold: got count=%0d busy=%b, want %0d 1", cnt8, busy8, i);
                end
            end
            in_valid = 1'b1; a = 4'h3;
            tick();
        end
        in_valid = 1'b0;
        n_checks++;
        if (done8 !== 1'b1 || sum8 !== 8'h18 || cnt8 !== 4'd8) begin
            n_fail++; $display("FAIL gap_result: got done=%b sum=%h count=%0d, want 1 18 8", done8, sum8, cnt8);
        end
    endtask

    task automatic test_wrap4();
        logic [3:0] seq [8] = '{4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = seq[i];
            tick();
            n_checks++;
            if (i == 0 && (sum4 !== 4'h7 || ovf4 !== 1'b0)) begin
                n_fail++; $display("FAIL wrap_first: got sum=%h ovf=%b, want 7 0", sum4, ovf4);
            end else if (i > 0 && (sum4 !== 4'hE || ovf4 !== 1'b1)) begin
                n_fail++; $display("FAIL wrap_sticky: sample %0d got sum=%h ovf=%b, want e 1", i, sum4, ovf4);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (done4 !== 1'b1 || sum8 !== 8'h0E || ovf8 !== 1'b0) begin
            n_fail++; $display("FAIL wrap_done: got done4=%b sum8=%h ovf8=%b, want 1 0e 0", done4, sum8, ovf8);
        end
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (ovf4 !== 1'b0 || sum4 !== 4'h0 || busy4 !== 1'b1) begin
            n_fail++; $display("FAIL wrap_restart: got ovf=%b sum=%h busy=%b, want 0 0 1", ovf4, sum4, busy4);
        end
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 4'h5; tick();
        end
        n_checks++;
        if (sum8 !== 8'd15 || cnt8 !== 4'd3) begin
            n_fail++; $display("FAIL mid_pre: got sum=%h count=%0d, want 0f 3", sum8, cnt8);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if ({busy8, done8, sum8, cnt8, ovf8} !== 15'd0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b done=%b sum=%h count=%0d ovf=%b, want all 0",
                               busy8, done8, sum8, cnt8, ovf8);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 4'h5; tick();
            n_checks++;
            if (sum8 !== 8'd0 || cnt8 !== 4'd0 || busy8 !== 1'b0) begin
                n_fail++; $display("FAIL mid_ignore: got sum=%h count=%0d busy=%b, want 0 0 0", sum8, cnt8, busy8);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 4'h7; tick();
            n_checks++;
            if (sum8 !== 8'd0 || cnt8 !== 4'd0) begin
                n_fail++; $display("FAIL idle_valid: got sum=%h count=%0d, want 0 0", sum8, cnt8);
            end
        end
        start = 1'b1; in_valid = 1'b1; a = 4'h7; tick(); start = 1'b0;
        n_checks++;
        if (sum8 !== 8'd0 || cnt8 !== 4'd0 || busy8 !== 1'b1) begin
            n_fail++; $display("FAIL start_valid: got sum=%h count=%0d busy=%b, want 0 0 1", sum8, cnt8, busy8);
        end
        a = 4'h1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (cnt8 !== 4'd4 || sum8 !== 8'd4 || busy8 !== 1'b1) begin
            n_fail++; $display("FAIL acc_start: got count=%0d sum=%h busy=%b, want 4 04 1", cnt8, sum8, busy8);
        end
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        n_checks++;
        if (done8 !== 1'b1 || sum8 !== 8'd8) begin
            n_fail++; $display("FAIL acc_done: got done=%b sum=%h, want 1 08", done8, sum8);
        end
        start = 1'b1; tick();
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'd8) begin
            n_fail++; $display("FAIL done_start: got busy=%b done=%b sum=%h, want 0 0 08", busy8, done8, sum8);
        end
        tick(); start = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1 || sum8 !== 8'd0 || cnt8 !== 4'd0) begin
            n_fail++; $display("FAIL back_to_back: got busy=%b sum=%h count=%0d, want 1 00 0", busy8, sum8, cnt8);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            a        = 4'($urandom_range(0, 15));
            tick();
            n_checks++;
            if (int'($signed(sum8)) != m_sum[0] || int'(cnt8) != m_cnt[0] || int'(ovf8) != m_ovf[0] ||
                busy8 !== (m_state[0] == 1) || done8 !== (m_state[0] == 2)) begin
                n_fail++;
                $display("FAIL rand8: cycle %0d got sum=%0d cnt=%0d ovf=%b busy=%b done=%b, want %0d %0d %0d st=%0d",
                         c, $signed(sum8), cnt8, ovf8, busy8, done8, m_sum[0], m_cnt[0], m_ovf[0], m_state[0]);
            end
            n_checks++;
            if (int'($signed(sum4)) != m_sum[1] || int'(cnt4) != m_cnt[1] || int'(ovf4) != m_ovf[1] ||
                busy4 !== (m_state[1] == 1) || done4 !== (m_state[1] == 2)) begin
                n_fail++;
                $display("FAIL rand4: cycle %0d got sum=%0d cnt=%0d ovf=%b busy=%b done=%b, want %0d %0d %0d st=%0d",
                         c, $signed(sum4), cnt4, ovf4, busy4, done4, m_sum[1], m_cnt[1], m_ovf[1], m_state[1]);
            end
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
        #2;
        test_reset();
        test_minus_one();
        test_alternating();
        test_gaps();
        test_wrap4();
        test_reset_midrun();
        test_ignored_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
